// File: rtl/wb_queue.sv
// Write-back queue in front of the GPR file: merges load returns and ALU results into one ordered write stream.
// Optional decode-stage forwarding from queued entries is built when WB_FWD_EN is defined.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_dst,
  input  logic [31:0] mem_data,
  input  logic        alu_valid,
  input  logic [4:0]  alu_dst,
  input  logic [31:0] alu_data,
  input  logic        alu_ovf,
  output logic        wb_stall,
  output logic        wb_err,
  output logic        gpr_we,
  output logic [4:0]  gpr_writereg,
  output logic [31:0] gpr_writedata,
  output logic        gpr_upover,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  typedef struct packed {
    logic        we;
    logic        ovf;
    logic [4:0]  dst;
    logic [31:0] data;
  } entry_t;

  localparam logic [PTR_W:0] STALL_ABOVE = (PTR_W+1)'(DEPTH - 2);

  entry_t           q_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic             mem_push;
  logic             alu_push;
  logic             pop;
  logic [1:0]       npush;
  logic [PTR_W-1:0] alu_slot;
  entry_t           mem_ent;
  entry_t           alu_ent;
  entry_t           head;

  assign wb_stall = (count > STALL_ABOVE);
  assign pop      = (count != '0);

  assign mem_push = !wb_stall && mem_valid && (mem_dst != 5'd0);
  // An overflowing addi is queued even to r0 so the trap strobe still reaches the file.
  assign alu_push = !wb_stall && alu_valid && (alu_ovf || (alu_dst != 5'd0));
  assign npush    = {1'b0, mem_push} + {1'b0, alu_push};
  assign alu_slot = wr_ptr + PTR_W'(mem_push);

  assign mem_ent = '{we: 1'b1, ovf: 1'b0, dst: mem_dst, data: mem_data};
  assign alu_ent = '{we: !alu_ovf, ovf: alu_ovf, dst: alu_dst, data: alu_data};

  always_ff @(posedge clk) begin
    if (mem_push) q_mem[wr_ptr] <= mem_ent;
    if (alu_push) q_mem[alu_slot] <= alu_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      wb_err <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(npush);
      count  <= count + (PTR_W+1)'(npush) - (PTR_W+1)'(pop);
      if (wb_stall && (mem_valid || alu_valid)) wb_err <= 1'b1;
    end
  end

  assign head = q_mem[rd_ptr];

  always_comb begin
    gpr_we        = 1'b0;
    gpr_upover    = 1'b0;
    gpr_writereg  = 5'd0;
    gpr_writedata = 32'd0;
    if (pop) begin
      gpr_we        = head.we;
      gpr_upover    = head.ovf;
      gpr_writereg  = head.dst;
      gpr_writedata = head.data;
    end
  end

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = 32'd0;
    fwd_data2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && q_mem[rd_ptr + PTR_W'(i)].we) begin
        if ((rd_addr1 != 5'd0) && (q_mem[rd_ptr + PTR_W'(i)].dst == rd_addr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = q_mem[rd_ptr + PTR_W'(i)].data;
        end
        if ((rd_addr2 != 5'd0) && (q_mem[rd_ptr + PTR_W'(i)].dst == rd_addr2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = q_mem[rd_ptr + PTR_W'(i)].data;
        end
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = 32'd0;
  assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, hand sequences for stall/reset, then random traffic vs a queue model.
module tb_wb_queue;
  localparam int DEPTH = 4;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [4:0]  mem_dst;
  logic [31:0] mem_data;
  logic        alu_valid;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        alu_ovf;
  logic        wb_stall;
  logic        wb_err;
  logic        gpr_we;
  logic [4:0]  gpr_writereg;
  logic [31:0] gpr_writedata;
  logic        gpr_upover;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;

  wb_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ovf(alu_ovf),
    .wb_stall(wb_stall), .wb_err(wb_err),
    .gpr_we(gpr_we), .gpr_writereg(gpr_writereg), .gpr_writedata(gpr_writedata), .gpr_upover(gpr_upover),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        ovf;
    logic [4:0]  dst;
    logic [31:0] data;
  } ment_t;

  typedef struct {
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mdat;
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adat;
    logic        ao;
    logic [4:0]  r1;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_ovf;
    logic        e_hit1;
    logic [31:0] e_fd1;
  } vec_t;

  ment_t q[$];
  logic  m_err;
  int    checks;
  int    errors;
  vec_t  vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                              input logic av, input logic [4:0] ad, input logic [31:0] adat,
                              input logic ao, input logic [4:0] r1,
                              input logic e_we, input logic [4:0] e_reg, input logic [31:0] e_data,
                              input logic e_ovf, input logic e_hit1, input logic [31:0] e_fd1);
    vec_t v;
    v.mv = mv; v.md = md; v.mdat = mdat; v.av = av; v.ad = ad; v.adat = adat; v.ao = ao; v.r1 = r1;
    v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data; v.e_ovf = e_ovf; v.e_hit1 = e_hit1; v.e_fd1 = e_fd1;
    return v;
  endfunction

  task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                       input logic av, input logic [4:0] ad, input logic [31:0] adat,
                       input logic ao, input logic [4:0] r1, input logic [4:0] r2);
    mem_valid = mv; mem_dst = md; mem_data = mdat;
    alu_valid = av; alu_dst = ad; alu_data = adat; alu_ovf = ao;
    rd_addr1 = r1; rd_addr2 = r2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  // Youngest queued entry that writes the given register wins.
  task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
    if (FWD && a != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].we && q[i].dst == a) begin
          hit = 1'b1;
          d   = q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    logic        h1, h2;
    logic [31:0] d1, d2;
    if (q.size() > 0) begin
      chk("gpr_we", gpr_we, q[0].we);
      chk("gpr_upover", gpr_upover, q[0].ovf);
      chk("gpr_writereg", gpr_writereg, q[0].dst);
      chk("gpr_writedata", gpr_writedata, q[0].data);
    end else begin
      chk("gpr_we_empty", gpr_we, 0);
      chk("gpr_upover_empty", gpr_upover, 0);
      chk("gpr_writereg_empty", gpr_writereg, 0);
      chk("gpr_writedata_empty", gpr_writedata, 0);
    end
    chk("wb_stall", wb_stall, (q.size() > DEPTH - 2));
    chk("wb_err", wb_err, m_err);
    model_fwd(rd_addr1, h1, d1);
    model_fwd(rd_addr2, h2, d2);
    chk("fwd_hit1", fwd_hit1, h1);
    chk("fwd_data1", fwd_data1, d1);
    chk("fwd_hit2", fwd_hit2, h2);
    chk("fwd_data2", fwd_data2, d2);
  endtask

  task automatic advance();
    bit stalled;
    stalled = (q.size() > DEPTH - 2);
    if (q.size() > 0) void'(q.pop_front());
    if (stalled) begin
      if (mem_valid || alu_valid) m_err = 1'b1;
    end else begin
      if (mem_valid && mem_dst != 5'd0) q.push_back('{1'b1, 1'b0, mem_dst, mem_data});
      if (alu_valid) begin
        if (alu_ovf) q.push_back('{1'b0, 1'b1, alu_dst, alu_data});
        else if (alu_dst != 5'd0) q.push_back('{1'b1, 1'b0, alu_dst, alu_data});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    check_model();
    advance();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_err  = 1'b0;
    rst    = 1'b0;
    idle();
    #2;
    chk("reset_we", gpr_we, 0);
    chk("reset_stall", wb_stall, 0);
    chk("reset_err", wb_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed table: expected outputs are those visible while the row's inputs are applied.
    vt[0] = mk(0, 0, 0,     1, 5, 32'h1234, 0, 0, 0, 0, 0,        0, 0, 0);
    vt[1] = mk(0, 0, 0,     0, 0, 0,        0, 0, 1, 5, 32'h1234, 0, 0, 0);
    vt[2] = mk(1, 3, 32'hA, 1, 3, 32'hB,    0, 0, 0, 0, 0,        0, 0, 0);
    vt[3] = mk(0, 0, 0,     0, 0, 0,        0, 3, 1, 3, 32'hA,    0, FWD, FWD ? 32'hB : 32'h0);
    vt[4] = mk(0, 0, 0,     0, 0, 0,        0, 3, 1, 3, 32'hB,    0, FWD, FWD ? 32'hB : 32'h0);
    vt[5] = mk(0, 0, 0,     1, 8, 32'h77,   1, 0, 0, 0, 0,        0, 0, 0);
    vt[6] = mk(0, 0, 0,     1, 0, 32'h55,   0, 0, 0, 8, 32'h77,   1, 0, 0);
    vt[7] = mk(0, 0, 0,     0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0);
    vt[8] = mk(1, 0, 32'h9, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0);
    vt[9] = mk(0, 0, 0,     0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].mv, vt[i].md, vt[i].mdat, vt[i].av, vt[i].ad, vt[i].adat, vt[i].ao, vt[i].r1, 5'd0);
      #1;
      chk($sformatf("vec%0d_we", i), gpr_we, vt[i].e_we);
      chk($sformatf("vec%0d_reg", i), gpr_writereg, vt[i].e_reg);
      chk($sformatf("vec%0d_data", i), gpr_writedata, vt[i].e_data);
      chk($sformatf("vec%0d_ovf", i), gpr_upover, vt[i].e_ovf);
      chk($sformatf("vec%0d_hit1", i), fwd_hit1, vt[i].e_hit1);
      chk($sformatf("vec%0d_fd1", i), fwd_data1, vt[i].e_fd1);
      check_model();
      advance();
    end

    // Fill to the stall threshold, try a request while stalled, drain.
    drive(1, 1, 32'h100, 1, 2, 32'h200, 0, 1, 2);
    #1; chk("fill1_stall", wb_stall, 0); check_model(); advance();
    drive(1, 4, 32'h400, 1, 5, 32'h500, 0, 4, 5);
    #1; chk("fill2_stall", wb_stall, 0); check_model(); advance();
    drive(1, 6, 32'h600, 0, 0, 0, 0, 6, 0);
    #1; chk("stalled", wb_stall, 1); check_model(); advance();
    idle();
    #1;
    chk("stall_drop", wb_stall, 0);
    chk("err_set", wb_err, 1);
    chk("drain_head", gpr_writereg, 4);
    chk("no_fwd_r6", fwd_hit1, 0);
    check_model(); advance();
    step();
    step();

    // Asynchronous reset with three entries pending.
    drive(1, 7, 32'h700, 1, 9, 32'h900, 0, 0, 0); step();
    drive(1, 10, 32'hA00, 1, 11, 32'hB00, 0, 9, 10); step();
    idle();
    rd_addr1 = 5'd9;
    #2;
    chk("pre_rst_stall", wb_stall, 1);
    rst = 1'b0;
    #1;
    chk("async_we", gpr_we, 0);
    chk("async_reg", gpr_writereg, 0);
    chk("async_data", gpr_writedata, 0);
    chk("async_stall", wb_stall, 0);
    chk("async_err", wb_err, 0);
    chk("async_hit1", fwd_hit1, 0);
    q.delete();
    m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Random traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
      if (n == 200 && m_err) begin
        idle();
        rst = 1'b0;
        q.delete();
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
